uart_rx_frame_ctrl: RTL

// Parametrised UART receive frame controller; the next-generation RX sequencer.

---
 rtl/uart_rx_frame_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampling UART receive sequencer with runtime length/parity/stop config
module uart_rx_frame_ctrl #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     tick_i,
    input  logic                     rx_i,
    input  logic [3:0]               data_bits_i,
    input  logic                     parity_en_i,
    input  logic                     parity_odd_i,
    input  logic                     stop2_i,
    output logic [MAX_DATA_BITS-1:0] data_o,
    output logic                     data_valid_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     busy_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;
    state_t                   r_state, w_next;
    logic [CW-1:0]            r_cnt;
    logic [3:0]               r_idx, r_nbits, w_nbits;
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic                     r_par_en, r_par_odd, r_stop2, r_perr, r_ferr, r_armed;
    logic                     w_mid, w_end, w_last, w_done, w_ferr, w_start;
    assign w_mid   = tick_i && r_cnt == CW'(OVERSAMPLE / 2 - 1);
    assign w_end   = tick_i && r_cnt == CW'(OVERSAMPLE - 1);
    assign w_last  = r_idx == r_nbits - 4'd1;
    assign w_ferr  = r_ferr | ~rx_i;
    assign w_start = r_state == S_IDLE && tick_i && !rx_i && r_armed;
    assign w_nbits = data_bits_i < 4'd5 ? 4'd5 :
                     (data_bits_i > 4'(MAX_DATA_BITS) ? 4'(MAX_DATA_BITS) : data_bits_i);
    assign busy_o  = r_state != S_IDLE;
    always_ff @(posedge clk_i) begin
        r_state <= srst_i ? S_IDLE : w_next;
    end
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   w_next = w_start ? S_START : S_IDLE;
            S_START:  w_next = w_mid ? (rx_i ? S_IDLE : S_DATA) : S_START;
            S_DATA:   w_next = (w_end && w_last) ? (r_par_en ? S_PARITY : S_STOP1) : S_DATA;
            S_PARITY: w_next = w_end ? S_STOP1 : S_PARITY;
            S_STOP1: begin
                w_next = w_end ? (r_stop2 ? S_STOP2 : S_IDLE) : S_STOP1;
                w_done = w_end && !r_stop2;
            end
            S_STOP2: begin
                w_next = w_end ? S_IDLE : S_STOP2;
                w_done = w_end;
            end
            default:  w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_nbits      <= 4'd5;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_stop2      <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_armed      <= 1'b1;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            data_valid_o <= w_done;
            if (tick_i)
                r_cnt <= (r_state == S_IDLE || (r_state == S_START ? w_mid : w_end)) ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE && tick_i && rx_i)
                r_armed <= 1'b1;
            if (w_start) begin
                r_nbits   <= w_nbits;
                r_par_en  <= parity_en_i;
                r_par_odd <= parity_odd_i;
                r_stop2   <= stop2_i;
                r_idx     <= '0;
                r_shift   <= '0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end
            if (r_state == S_DATA && w_end) begin
                r_shift <= {rx_i, r_shift[MAX_DATA_BITS-1:1]};
                r_idx   <= r_idx + 4'd1;
            end
            // unused low bits of the shift register stay zero, so ^r_shift is the data parity
            if (r_state == S_PARITY && w_end)
                r_perr <= (^r_shift ^ rx_i) != r_par_odd;
            if (r_state == S_STOP1 && w_end && !rx_i)
                r_ferr <= 1'b1;
            if (w_done) begin
                data_o       <= r_shift >> (4'(MAX_DATA_BITS) - r_nbits);
                parity_err_o <= r_perr;
                frame_err_o  <= w_ferr;
                if (w_ferr)
                    r_armed <= 1'b0;
            end
        end
    end
endmodule
